// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the video PLL configuration sequencer: keyboard
// scancodes for the number-row keys, scheme width and FSM state encoding.
package pll_cfg_pkg;

    localparam int SCHEME_W = 3;

    typedef logic [SCHEME_W-1:0] scheme_t;

    // Set-2 make codes for the number-row keys 1..8
    localparam logic [7:0] SC_KEY_1 = 8'h16;
    localparam logic [7:0] SC_KEY_2 = 8'h1E;
    localparam logic [7:0] SC_KEY_3 = 8'h26;
    localparam logic [7:0] SC_KEY_4 = 8'h25;
    localparam logic [7:0] SC_KEY_5 = 8'h2E;
    localparam logic [7:0] SC_KEY_6 = 8'h36;
    localparam logic [7:0] SC_KEY_7 = 8'h3D;
    localparam logic [7:0] SC_KEY_8 = 8'h3E;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/pll_cfg_sequencer_if.sv
// Bundles the keyboard-event inputs, the PLL step/ready handshake and the
// status outputs of the PLL configuration sequencer.
interface pll_cfg_sequencer_if import pll_cfg_pkg::*; ();

    logic       kb_interrupt;
    logic [7:0] scancode;
    logic       released;
    logic       extended;
    logic       srdy;
    logic       sstep;
    scheme_t    state_sel;
    logic       busy;
    scheme_t    cur_scheme;
    logic       cfg_error;

    modport slave (
        input  kb_interrupt, scancode, released, extended, srdy,
        output sstep, state_sel, busy, cur_scheme, cfg_error
    );

    modport master (
        output kb_interrupt, scancode, released, extended, srdy,
        input  sstep, state_sel, busy, cur_scheme, cfg_error
    );

endinterface

// File: rtl/pll_key_decode.sv
// Combinational decode of a PS/2 key event into a PLL scheme request.
// Only make codes of the unprefixed number-row keys 1..8 produce a request.
module pll_key_decode import pll_cfg_pkg::*; (
    input  logic [7:0] scancode,
    input  logic       released,
    input  logic       extended,
    output logic       valid,
    output scheme_t    scheme
);

    logic    key_hit_s;
    scheme_t key_scheme_s;

    // Map the number-row scancode to its scheme index
    always_comb begin
        key_hit_s    = 1'b0;
        key_scheme_s = 3'd0;
        case (scancode)
            SC_KEY_1: begin key_hit_s = 1'b1; key_scheme_s = 3'd0; end
            SC_KEY_2: begin key_hit_s = 1'b1; key_scheme_s = 3'd1; end
            SC_KEY_3: begin key_hit_s = 1'b1; key_scheme_s = 3'd2; end
            SC_KEY_4: begin key_hit_s = 1'b1; key_scheme_s = 3'd3; end
            SC_KEY_5: begin key_hit_s = 1'b1; key_scheme_s = 3'd4; end
            SC_KEY_6: begin key_hit_s = 1'b1; key_scheme_s = 3'd5; end
            SC_KEY_7: begin key_hit_s = 1'b1; key_scheme_s = 3'd6; end
            SC_KEY_8: begin key_hit_s = 1'b1; key_scheme_s = 3'd7; end
            default:  begin key_hit_s = 1'b0; key_scheme_s = 3'd0; end
        endcase
    end

    // Break codes and E0-prefixed codes (keypad etc.) never select a scheme
    always_comb begin
        valid  = 1'b0;
        scheme = 3'd0;
        if (released || extended) begin
            valid  = 1'b0;
            scheme = 3'd0;
        end else begin
            valid  = key_hit_s;
            scheme = key_scheme_s;
        end
    end

endmodule

// File: rtl/pll_cfg_sequencer.sv
// Turns number-row key presses into video PLL reconfiguration requests.
// Holds one pending request (latest wins), issues a one-cycle sstep, waits
// for srdy with a timeout, and tracks the acknowledged scheme and errors.
module pll_cfg_sequencer import pll_cfg_pkg::*; #(
    parameter scheme_t     DEFAULT_SCHEME = 3'd0,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 32'd65535
) (
    input  logic                clk,
    input  logic                rst,
    pll_cfg_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             dec_valid_s;
    scheme_t          dec_scheme_s;

    cfg_state_e       state_r;
    cfg_state_e       state_next_s;
    logic             pend_valid_r;
    logic             pend_valid_next_s;
    scheme_t          pend_scheme_r;
    scheme_t          pend_scheme_next_s;
    scheme_t          state_sel_r;
    scheme_t          state_sel_next_s;
    scheme_t          cur_scheme_r;
    scheme_t          cur_scheme_next_s;
    logic             cfg_error_r;
    logic             cfg_error_next_s;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic [CNT_W-1:0] tmo_cnt_next_s;
    logic             sstep_r;
    logic             busy_r;

    logic             req_s;
    logic             req_drop_s;
    logic             consume_s;

    pll_key_decode u_decode (
        .scancode (bus.scancode),
        .released (bus.released),
        .extended (bus.extended),
        .valid    (dec_valid_s),
        .scheme   (dec_scheme_s)
    );

    // Qualify the key event; a request for the already-active scheme is
    // redundant only when nothing is queued, nothing is running and the
    // last reconfiguration succeeded
    always_comb begin
        req_s      = bus.kb_interrupt & dec_valid_s;
        req_drop_s = 1'b0;
        if ((dec_scheme_s == cur_scheme_r) && !pend_valid_r &&
            (state_r == IDLE) && !cfg_error_r) begin
            req_drop_s = 1'b1;
        end else begin
            req_drop_s = 1'b0;
        end
    end

    // Sequencer next-state logic: issue, then wait for ready or timeout
    always_comb begin
        state_next_s      = state_r;
        state_sel_next_s  = state_sel_r;
        cur_scheme_next_s = cur_scheme_r;
        cfg_error_next_s  = cfg_error_r;
        tmo_cnt_next_s    = tmo_cnt_r;
        consume_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_valid_r) begin
                    state_sel_next_s = pend_scheme_r;
                    consume_s        = 1'b1;
                    state_next_s     = ISSUE;
                end else begin
                    state_next_s     = IDLE;
                end
            end
            ISSUE: begin
                tmo_cnt_next_s = CNT_ZERO;
                state_next_s   = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (bus.srdy) begin
                    cur_scheme_next_s = state_sel_r;
                    cfg_error_next_s  = 1'b0;
                    state_next_s      = IDLE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    cfg_error_next_s  = 1'b1;
                    state_next_s      = IDLE;
                end else begin
                    tmo_cnt_next_s    = tmo_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One-deep pending slot: a new request wins over both the held entry
    // and the IDLE consume happening in the same cycle
    always_comb begin
        pend_valid_next_s  = pend_valid_r;
        pend_scheme_next_s = pend_scheme_r;
        if (req_s && !req_drop_s) begin
            pend_valid_next_s  = 1'b1;
            pend_scheme_next_s = dec_scheme_s;
        end else if (consume_s) begin
            pend_valid_next_s  = 1'b0;
            pend_scheme_next_s = pend_scheme_r;
        end else begin
            pend_valid_next_s  = pend_valid_r;
            pend_scheme_next_s = pend_scheme_r;
        end
    end

    // Sequencer state, pending slot and scheme tracking registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            pend_valid_r  <= AUTO_START;
            pend_scheme_r <= DEFAULT_SCHEME;
            state_sel_r   <= DEFAULT_SCHEME;
            cur_scheme_r  <= DEFAULT_SCHEME;
            cfg_error_r   <= 1'b0;
            tmo_cnt_r     <= CNT_ZERO;
        end else begin
            state_r       <= state_next_s;
            pend_valid_r  <= pend_valid_next_s;
            pend_scheme_r <= pend_scheme_next_s;
            state_sel_r   <= state_sel_next_s;
            cur_scheme_r  <= cur_scheme_next_s;
            cfg_error_r   <= cfg_error_next_s;
            tmo_cnt_r     <= tmo_cnt_next_s;
        end
    end

    // Registered strobe and busy flag; sstep follows the ISSUE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sstep_r <= 1'b0;
            busy_r  <= AUTO_START;
        end else begin
            sstep_r <= (state_r == ISSUE);
            busy_r  <= pend_valid_next_s | (state_next_s != IDLE);
        end
    end

    assign bus.sstep      = sstep_r;
    assign bus.state_sel  = state_sel_r;
    assign bus.busy       = busy_r;
    assign bus.cur_scheme = cur_scheme_r;
    assign bus.cfg_error  = cfg_error_r;

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Directed testbench for pll_cfg_sequencer with a scoreboard of expected
// state_sel values checked whenever sstep fires.
module tb_pll_cfg_sequencer;
    import pll_cfg_pkg::*;

    localparam scheme_t DEF = 3'd3;
    localparam int      TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pll_cfg_sequencer_if bus ();

    pll_cfg_sequencer #(
        .DEFAULT_SCHEME (DEF),
        .AUTO_START     (1'b1),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int      n_tests     = 0;
    int      n_fail      = 0;
    int      sstep_total = 0;
    int      exp_sstep   = 0;
    scheme_t exp_q[$];

    // count every cycle in which sstep is high
    always @(negedge clk) begin
        if (bus.sstep === 1'b1) sstep_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [7:0] code, input logic rel, input logic ext);
        bus.scancode     = code;
        bus.released     = rel;
        bus.extended     = ext;
        bus.kb_interrupt = 1'b1;
        tick();
        bus.kb_interrupt = 1'b0;
        bus.released     = 1'b0;
        bus.extended     = 1'b0;
    endtask

    task automatic pulse_srdy();
        bus.srdy = 1'b1;
        tick();
        bus.srdy = 1'b0;
    endtask

    task automatic expect_issue(input scheme_t s);
        exp_q.push_back(s);
        exp_sstep++;
    endtask

    // latency is counted in negedges from the current cycle (1 = this cycle)
    task automatic wait_sstep(input string tag, input int exp_lat);
        int      cnt;
        bit      seen;
        scheme_t e;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 64) begin
            @(negedge clk);
            cnt++;
            if (bus.sstep === 1'b1) seen = 1'b1;
        end
        chk({tag, " sstep_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, " latency"}, 32'(cnt), 32'(exp_lat));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, " state_sel"}, 32'(bus.state_sel), 32'(e));
            end else begin
                chk({tag, " scoreboard_entry"}, 32'(exp_q.size()), 32'd1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.kb_interrupt = 1'b0;
        bus.scancode     = 8'h00;
        bus.released     = 1'b0;
        bus.extended     = 1'b0;
        bus.srdy         = 1'b0;
        rst              = 1'b1;

        // reset values
        ticks(3);
        @(negedge clk);
        chk("rst sstep",      32'(bus.sstep),      32'd0);
        chk("rst state_sel",  32'(bus.state_sel),  32'(DEF));
        chk("rst busy",       32'(bus.busy),       32'd1);
        chk("rst cur_scheme", 32'(bus.cur_scheme), 32'(DEF));
        chk("rst cfg_error",  32'(bus.cfg_error),  32'd0);

        // auto start: sstep in cycle 2 after release, then srdy 10 cycles on
        tick();
        rst = 1'b0;
        expect_issue(DEF);
        wait_sstep("auto", 3);
        tick();
        chk("auto busy_wait", 32'(bus.busy), 32'd1);
        ticks(8);
        pulse_srdy();
        @(negedge clk);
        chk("auto cur_scheme", 32'(bus.cur_scheme), 32'd3);
        chk("auto busy_done",  32'(bus.busy),       32'd0);
        chk("auto cfg_error",  32'(bus.cfg_error),  32'd0);
        tick();

        // key 3 make code -> scheme 2, sstep at N+3
        press(8'h26, 1'b0, 1'b0);
        expect_issue(3'd2);
        wait_sstep("key3", 3);
        tick();
        ticks(3);
        pulse_srdy();
        @(negedge clk);
        chk("key3 cur_scheme", 32'(bus.cur_scheme), 32'd2);
        tick();

        // break, extended and unmapped codes are ignored
        press(8'h26, 1'b1, 1'b0);
        press(8'h26, 1'b0, 1'b1);
        press(8'h1C, 1'b0, 1'b0);
        ticks(5);
        chk("ignored sstep_count", 32'(sstep_total), 32'(exp_sstep));
        chk("ignored busy",        32'(bus.busy),    32'd0);

        // in-flight scheme 1: key 5 then key 7 together with srdy; 7 wins
        press(8'h1E, 1'b0, 1'b0);
        expect_issue(3'd1);
        wait_sstep("key2", 3);
        tick();
        press(8'h2E, 1'b0, 1'b0);
        bus.srdy = 1'b1;
        press(8'h3D, 1'b0, 1'b0);
        bus.srdy = 1'b0;
        expect_issue(3'd6);
        wait_sstep("latest_wins", 3);
        chk("latest_wins cur_scheme", 32'(bus.cur_scheme), 32'd1);
        chk("latest_wins busy",       32'(bus.busy),       32'd1);
        tick();
        ticks(2);
        pulse_srdy();
        @(negedge clk);
        chk("latest_wins cur_after", 32'(bus.cur_scheme), 32'd6);
        tick();
        ticks(4);
        chk("latest_wins sstep_count", 32'(sstep_total),   32'(exp_sstep));
        chk("latest_wins queue_empty", 32'(exp_q.size()),  32'd0);

        // timeout: no srdy, error and idle 16 cycles after WAIT_RDY entry
        press(8'h16, 1'b0, 1'b0);
        expect_issue(3'd0);
        wait_sstep("tmo", 3);
        repeat (TMO - 1) @(negedge clk);
        chk("tmo err_before", 32'(bus.cfg_error), 32'd0);
        @(negedge clk);
        chk("tmo cfg_error",  32'(bus.cfg_error),  32'd1);
        chk("tmo busy",       32'(bus.busy),       32'd0);
        chk("tmo cur_scheme", 32'(bus.cur_scheme), 32'd6);
        tick();

        // same scheme as current is reissued while cfg_error is set;
        // srdy during IDLE and ISSUE must be ignored
        press(8'h3D, 1'b0, 1'b0);
        expect_issue(3'd6);
        bus.srdy = 1'b1;
        tick();
        tick();
        bus.srdy = 1'b0;
        wait_sstep("err_reissue", 1);
        chk("err_reissue cfg_error",  32'(bus.cfg_error),  32'd1);
        chk("err_reissue cur_scheme", 32'(bus.cur_scheme), 32'd6);

        // pending written during WAIT_RDY issues right after the timeout
        tick();
        press(8'h2E, 1'b0, 1'b0);
        expect_issue(3'd4);
        wait_sstep("after_tmo", 17);
        chk("after_tmo cfg_error",  32'(bus.cfg_error),  32'd1);
        chk("after_tmo cur_scheme", 32'(bus.cur_scheme), 32'd6);
        tick();
        ticks(2);
        pulse_srdy();
        @(negedge clk);
        chk("after_tmo cur_after", 32'(bus.cur_scheme), 32'd4);
        chk("after_tmo err_clear", 32'(bus.cfg_error),  32'd0);
        tick();

        // request equal to current scheme with no error is dropped
        press(8'h2E, 1'b0, 1'b0);
        ticks(5);
        chk("drop sstep_count", 32'(sstep_total), 32'(exp_sstep));
        chk("drop busy",        32'(bus.busy),    32'd0);

        // reset two cycles after sstep, mid WAIT_RDY
        press(8'h3E, 1'b0, 1'b0);
        expect_issue(3'd7);
        wait_sstep("key8", 3);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst sstep",      32'(bus.sstep),      32'd0);
        chk("midrst state_sel",  32'(bus.state_sel),  32'(DEF));
        chk("midrst busy",       32'(bus.busy),       32'd1);
        chk("midrst cur_scheme", 32'(bus.cur_scheme), 32'(DEF));
        chk("midrst cfg_error",  32'(bus.cfg_error),  32'd0);
        ticks(2);

        // stale srdy right after release is ignored; default is reissued
        rst      = 1'b0;
        bus.srdy = 1'b1;
        expect_issue(DEF);
        tick();
        tick();
        bus.srdy = 1'b0;
        wait_sstep("reissue", 1);
        tick();
        ticks(3);
        chk("reissue busy_wait", 32'(bus.busy), 32'd1);
        pulse_srdy();
        @(negedge clk);
        chk("reissue cur_scheme", 32'(bus.cur_scheme), 32'(DEF));
        chk("reissue busy_done",  32'(bus.busy),       32'd0);
        tick();
        ticks(3);
        chk("final sstep_count", 32'(sstep_total),  32'(exp_sstep));
        chk("final queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
